// File: rtl/vehicle_control_multi_if.sv
// Driver-command and dashboard/lamp bundle of the vehicle control block.
// The decoder side uses the master modport and the control block uses the slave modport.
interface vehicle_control_multi_if #(
    parameter int NUM_FWD_GEARS = 5
);
    localparam int GW = $clog2(NUM_FWD_GEARS + 1);

    logic          _switch;
    logic          _brake;
    logic          _speedZero;
    logic          _gearValid;
    logic [1:0]    _gearShift;
    logic          _turnValid;
    logic [1:0]    _turnShift;
    logic [1:0]    _gearState;
    logic [GW-1:0] _gearIndex;
    logic          _shiftReject;
    logic [1:0]    _turnState;
    logic          _leftLamp;
    logic          _rightLamp;

    modport master (
        output _switch, _brake, _speedZero, _gearValid, _gearShift, _turnValid, _turnShift,
        input  _gearState, _gearIndex, _shiftReject, _turnState, _leftLamp, _rightLamp
    );

    modport slave (
        input  _switch, _brake, _speedZero, _gearValid, _gearShift, _turnValid, _turnShift,
        output _gearState, _gearIndex, _shiftReject, _turnState, _leftLamp, _rightLamp
    );
endinterface

// File: rtl/vehicle_control_multi.sv
// Gear selector with brake/speed interlocks plus turn/hazard FSM with lamp blinking.
// Every output is registered; strobed commands become visible one cycle later.
module vehicle_control_multi #(
    parameter int NUM_FWD_GEARS = 5,
    parameter int BLINK_HALF    = 4,
    parameter int AUTO_CANCEL   = 6,
    parameter int GW            = $clog2(NUM_FWD_GEARS + 1)
) (
    input  logic                    clock,
    input  logic                    _reset_n,
    vehicle_control_multi_if.slave  bus
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int CW = (AUTO_CANCEL > 0) ? $clog2(AUTO_CANCEL + 1) : 1;
    localparam logic [GW-1:0] TOP_GEAR  = GW'(NUM_FWD_GEARS);
    localparam logic [BW-1:0] HALF_LAST = BW'(BLINK_HALF - 1);
    localparam logic [CW-1:0] CANCEL_AT = CW'(AUTO_CANCEL);
    localparam bit            CANCEL_EN = (AUTO_CANCEL > 0);

    localparam logic [1:0] CMD_PARK    = 2'b00;
    localparam logic [1:0] CMD_REVERSE = 2'b01;
    localparam logic [1:0] CMD_DOWN    = 2'b10;
    localparam logic [1:0] CMD_UP      = 2'b11;
    localparam logic [1:0] TCMD_NONE   = 2'b00;
    localparam logic [1:0] TCMD_DOWN   = 2'b01;
    localparam logic [1:0] TCMD_UP     = 2'b10;
    localparam logic [1:0] TCMD_HAZARD = 2'b11;

    typedef enum logic [1:0] {
        GEAR_LOCK    = 2'b00,
        GEAR_PARK    = 2'b01,
        GEAR_REVERSE = 2'b10,
        GEAR_FORWARD = 2'b11
    } gear_state_e;

    typedef enum logic [1:0] {
        TURN_NONE   = 2'b00,
        TURN_LEFT   = 2'b01,
        TURN_HAZARD = 2'b10,
        TURN_RIGHT  = 2'b11
    } turn_state_e;

    gear_state_e   gear_state_r, gear_next_s;
    logic [GW-1:0] gear_index_r, index_next_s;
    logic          shift_reject_r, reject_next_s;
    turn_state_e   turn_state_r, turn_next_s;
    logic          phase_r, phase_next_s;
    logic [BW-1:0] blink_cnt_r, blink_next_s;
    logic [CW-1:0] cancel_cnt_r, cancel_next_s;
    logic          left_lamp_r, left_next_s;
    logic          right_lamp_r, right_next_s;
    logic          interlock_ok_s;
    logic          half_done_s;
    logic          steering_s;
    logic          cancel_due_s;
    logic [1:0]    turn_cmd_s;

    assign interlock_ok_s = bus._brake & bus._speedZero;
    assign half_done_s    = (blink_cnt_r == HALF_LAST);
    assign steering_s     = (turn_state_r == TURN_LEFT) || (turn_state_r == TURN_RIGHT);
    // Auto-cancel fires at the end of the off half that completes the last full period.
    assign cancel_due_s   = CANCEL_EN && steering_s && (cancel_cnt_r == CANCEL_AT)
                            && !phase_r && half_done_s;
    assign turn_cmd_s     = bus._turnValid ? bus._turnShift : TCMD_NONE;

    // Gear selection next state, index and reject decision
    always_comb begin
        gear_next_s   = gear_state_r;
        index_next_s  = gear_index_r;
        reject_next_s = 1'b0;
        if (!bus._switch) begin
            gear_next_s  = GEAR_LOCK;
            index_next_s = GW'(0);
        end else begin
            case (gear_state_r)
                GEAR_LOCK: begin
                    gear_next_s  = GEAR_PARK;
                    index_next_s = GW'(0);
                end
                GEAR_PARK: begin
                    index_next_s = GW'(0);
                    if (bus._gearValid) begin
                        case (bus._gearShift)
                            CMD_PARK:    gear_next_s = GEAR_PARK;
                            CMD_REVERSE: begin
                                if (interlock_ok_s) gear_next_s = GEAR_REVERSE;
                                else                reject_next_s = 1'b1;
                            end
                            CMD_UP: begin
                                if (interlock_ok_s) begin
                                    gear_next_s  = GEAR_FORWARD;
                                    index_next_s = GW'(1);
                                end else begin
                                    reject_next_s = 1'b1;
                                end
                            end
                            CMD_DOWN:    reject_next_s = 1'b1;
                            default:     reject_next_s = 1'b1;
                        endcase
                    end else begin
                        gear_next_s = GEAR_PARK;
                    end
                end
                GEAR_REVERSE: begin
                    index_next_s = GW'(0);
                    if (bus._gearValid) begin
                        case (bus._gearShift)
                            CMD_PARK: begin
                                if (bus._speedZero) gear_next_s = GEAR_PARK;
                                else                reject_next_s = 1'b1;
                            end
                            CMD_UP: begin
                                if (bus._speedZero) begin
                                    gear_next_s  = GEAR_FORWARD;
                                    index_next_s = GW'(1);
                                end else begin
                                    reject_next_s = 1'b1;
                                end
                            end
                            CMD_REVERSE: gear_next_s = GEAR_REVERSE;
                            CMD_DOWN:    reject_next_s = 1'b1;
                            default:     reject_next_s = 1'b1;
                        endcase
                    end else begin
                        gear_next_s = GEAR_REVERSE;
                    end
                end
                GEAR_FORWARD: begin
                    // A corrupted index is treated like an undefined state.
                    if ((gear_index_r == GW'(0)) || (gear_index_r > TOP_GEAR)) begin
                        gear_next_s  = GEAR_PARK;
                        index_next_s = GW'(0);
                    end else if (bus._gearValid) begin
                        case (bus._gearShift)
                            CMD_UP: begin
                                if (gear_index_r == TOP_GEAR) reject_next_s = 1'b1;
                                else                          index_next_s = gear_index_r + GW'(1);
                            end
                            CMD_DOWN: begin
                                if (gear_index_r == GW'(1)) reject_next_s = 1'b1;
                                else                        index_next_s = gear_index_r - GW'(1);
                            end
                            CMD_PARK, CMD_REVERSE: begin
                                if (bus._speedZero) begin
                                    gear_next_s  = (bus._gearShift == CMD_PARK) ? GEAR_PARK : GEAR_REVERSE;
                                    index_next_s = GW'(0);
                                end else begin
                                    reject_next_s = 1'b1;
                                end
                            end
                            default: reject_next_s = 1'b1;
                        endcase
                    end else begin
                        gear_next_s = GEAR_FORWARD;
                    end
                end
                default: begin
                    gear_next_s  = GEAR_PARK;
                    index_next_s = GW'(0);
                end
            endcase
        end
    end

    // Turn/hazard next state; hazard toggle has top priority, strobes beat auto-cancel
    always_comb begin
        turn_next_s = turn_state_r;
        if (turn_cmd_s == TCMD_HAZARD) begin
            if (turn_state_r == TURN_HAZARD) turn_next_s = TURN_NONE;
            else                             turn_next_s = TURN_HAZARD;
        end else if (!bus._switch) begin
            if (steering_s) turn_next_s = TURN_NONE;
            else            turn_next_s = turn_state_r;
        end else if (turn_cmd_s != TCMD_NONE) begin
            case (turn_state_r)
                TURN_NONE: begin
                    if (turn_cmd_s == TCMD_UP) turn_next_s = TURN_LEFT;
                    else                       turn_next_s = TURN_RIGHT;
                end
                TURN_LEFT: begin
                    if (turn_cmd_s == TCMD_DOWN) turn_next_s = TURN_NONE;
                    else                         turn_next_s = TURN_LEFT;
                end
                TURN_RIGHT: begin
                    if (turn_cmd_s == TCMD_UP) turn_next_s = TURN_NONE;
                    else                       turn_next_s = TURN_RIGHT;
                end
                default: turn_next_s = turn_state_r;
            endcase
        end else if (cancel_due_s) begin
            turn_next_s = TURN_NONE;
        end else begin
            turn_next_s = turn_state_r;
        end
    end

    // Blink phase, half-period counter, cancel counter and lamp drive
    always_comb begin
        phase_next_s  = phase_r;
        blink_next_s  = blink_cnt_r;
        cancel_next_s = cancel_cnt_r;
        if (turn_next_s != turn_state_r) begin
            phase_next_s  = (turn_next_s != TURN_NONE);
            blink_next_s  = BW'(0);
            cancel_next_s = CW'(0);
        end else if (turn_state_r != TURN_NONE) begin
            if (half_done_s) begin
                blink_next_s = BW'(0);
                phase_next_s = ~phase_r;
                if (phase_r) cancel_next_s = cancel_cnt_r + CW'(1);
                else         cancel_next_s = cancel_cnt_r;
            end else begin
                blink_next_s = blink_cnt_r + BW'(1);
            end
        end else begin
            phase_next_s  = 1'b0;
            blink_next_s  = BW'(0);
            cancel_next_s = CW'(0);
        end
        left_next_s  = phase_next_s & ((turn_next_s == TURN_LEFT)  || (turn_next_s == TURN_HAZARD));
        right_next_s = phase_next_s & ((turn_next_s == TURN_RIGHT) || (turn_next_s == TURN_HAZARD));
    end

    // Gear registers
    always_ff @(posedge clock or negedge _reset_n) begin
        if (!_reset_n) begin
            gear_state_r   <= GEAR_LOCK;
            gear_index_r   <= GW'(0);
            shift_reject_r <= 1'b0;
        end else begin
            gear_state_r   <= gear_next_s;
            gear_index_r   <= index_next_s;
            shift_reject_r <= reject_next_s;
        end
    end

    // Turn, blink and lamp registers
    always_ff @(posedge clock or negedge _reset_n) begin
        if (!_reset_n) begin
            turn_state_r <= TURN_NONE;
            phase_r      <= 1'b0;
            blink_cnt_r  <= BW'(0);
            cancel_cnt_r <= CW'(0);
            left_lamp_r  <= 1'b0;
            right_lamp_r <= 1'b0;
        end else begin
            turn_state_r <= turn_next_s;
            phase_r      <= phase_next_s;
            blink_cnt_r  <= blink_next_s;
            cancel_cnt_r <= cancel_next_s;
            left_lamp_r  <= left_next_s;
            right_lamp_r <= right_next_s;
        end
    end

    assign bus._gearState   = gear_state_r;
    assign bus._gearIndex   = gear_index_r;
    assign bus._shiftReject = shift_reject_r;
    assign bus._turnState   = turn_state_r;
    assign bus._leftLamp    = left_lamp_r;
    assign bus._rightLamp   = right_lamp_r;

endmodule

// File: tb/tb_vehicle_control_multi.sv
// Scoreboard bench for vehicle_control_multi: directed scenarios then randomized traffic,
// with expectations from a cycle-age based reference model.
module tb_vehicle_control_multi;

    localparam int NFG = 5;
    localparam int BH  = 4;
    localparam int AC  = 6;

    localparam logic [1:0] G_PARK = 2'b00, G_REV = 2'b01, G_DOWN = 2'b10, G_UP = 2'b11;
    localparam logic [1:0] T_NONE = 2'b00, T_DOWN = 2'b01, T_UP = 2'b10, T_HAZ = 2'b11;

    typedef struct {
        int gs;
        int gi;
        int rej;
        int ts;
        int ll;
        int rl;
    } exp_t;

    logic clock = 1'b0;
    logic _reset_n;
    always #5 clock = ~clock;

    vehicle_control_multi_if #(.NUM_FWD_GEARS(NFG)) bus();

    vehicle_control_multi #(
        .NUM_FWD_GEARS(NFG),
        .BLINK_HALF(BH),
        .AUTO_CANCEL(AC)
    ) dut (
        .clock(clock),
        ._reset_n(_reset_n),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: gear 0 LOCK 1 PARK 2 REV 3 FWD; turn 0 NONE 1 LEFT 3 RIGHT 2 HAZARD.
    // m_age counts cycles spent in the current turn state.
    int m_gear, m_idx, m_turn, m_age;
    bit lvl_sw, lvl_br, lvl_sz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gear = 0; m_idx = 0; m_turn = 0; m_age = 0;
    endtask

    task automatic model_step(input bit sw, input bit br, input bit sz, input bit gv,
                              input int gs, input bit tv, input int ts);
        int   ng, ni, nt;
        bit   rej, ok, ph;
        exp_t e;
        ng = m_gear; ni = m_idx; nt = m_turn; rej = 0; ok = br && sz;
        if (!sw) begin
            ng = 0; ni = 0;
        end else if (m_gear == 0) begin
            ng = 1;
        end else if (gv) begin
            if (m_gear == 1) begin
                if (gs == 1) begin if (ok) ng = 2; else rej = 1; end
                if (gs == 3) begin if (ok) begin ng = 3; ni = 1; end else rej = 1; end
                if (gs == 2) rej = 1;
            end else if (m_gear == 2) begin
                if (gs == 0) begin if (sz) ng = 1; else rej = 1; end
                if (gs == 3) begin if (sz) begin ng = 3; ni = 1; end else rej = 1; end
                if (gs == 2) rej = 1;
            end else begin
                if (gs == 3) begin if (m_idx < NFG) ni = m_idx + 1; else rej = 1; end
                if (gs == 2) begin if (m_idx > 1) ni = m_idx - 1; else rej = 1; end
                if (gs == 0 || gs == 1) begin
                    if (sz) begin ng = (gs == 0) ? 1 : 2; ni = 0; end else rej = 1;
                end
            end
        end
        if (tv && ts == 3) begin
            nt = (m_turn == 2) ? 0 : 2;
        end else if (!sw) begin
            if (m_turn == 1 || m_turn == 3) nt = 0;
        end else if (tv && ts != 0) begin
            if (m_turn == 0) nt = (ts == 2) ? 1 : 3;
            else if (m_turn == 1 && ts == 1) nt = 0;
            else if (m_turn == 3 && ts == 2) nt = 0;
        end else if ((m_turn == 1 || m_turn == 3) && AC > 0 && m_age + 1 == 2 * BH * AC) begin
            nt = 0;
        end
        if (nt != m_turn || nt == 0) m_age = 0;
        else m_age = m_age + 1;
        m_gear = ng; m_idx = ni; m_turn = nt;
        ph = (nt != 0) && ((m_age / BH) % 2 == 0);
        e.gs = ng; e.gi = ni; e.rej = int'(rej); e.ts = nt;
        e.ll = int'(ph && (nt == 1 || nt == 2));
        e.rl = int'(ph && (nt == 3 || nt == 2));
        exp_q.push_back(e);
    endtask

    task automatic apply(input bit gv, input logic [1:0] gs, input bit tv, input logic [1:0] ts);
        bus._switch = lvl_sw; bus._brake = lvl_br; bus._speedZero = lvl_sz;
        bus._gearValid = gv; bus._gearShift = gs;
        bus._turnValid = tv; bus._turnShift = ts;
        model_step(lvl_sw, lvl_br, lvl_sz, gv, int'(gs), tv, int'(ts));
    endtask

    task automatic cyc(input bit gv, input logic [1:0] gs, input bit tv, input logic [1:0] ts);
        @(negedge clock);
        apply(gv, gs, tv, ts);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, G_PARK, 1'b0, T_NONE);
    endtask

    task automatic release_reset();
        @(negedge clock);
        _reset_n = 1'b1;
        model_reset();
        apply(1'b0, G_PARK, 1'b0, T_NONE);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gear_state"}, int'(bus._gearState), 0);
        check({tag, "_gear_index"}, int'(bus._gearIndex), 0);
        check({tag, "_reject"}, int'(bus._shiftReject), 0);
        check({tag, "_turn_state"}, int'(bus._turnState), 0);
        check({tag, "_left_lamp"}, int'(bus._leftLamp), 0);
        check({tag, "_right_lamp"}, int'(bus._rightLamp), 0);
    endtask

    task automatic run_random(input int n, input int tv_pct, input int gv_pct, input int off_pct);
        for (int i = 0; i < n; i++) begin
            lvl_sw = ($urandom_range(99, 0) >= off_pct);
            lvl_br = ($urandom_range(99, 0) < 70);
            lvl_sz = ($urandom_range(99, 0) < 70);
            cyc($urandom_range(99, 0) < gv_pct, 2'($urandom_range(3, 0)),
                $urandom_range(99, 0) < tv_pct, 2'($urandom_range(3, 0)));
        end
    endtask

    // Monitor: every clock edge out of reset retires one expected output set.
    always @(posedge clock) begin
        #1;
        if (_reset_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("gear_state", int'(bus._gearState), mon_e.gs);
            check("gear_index", int'(bus._gearIndex), mon_e.gi);
            check("shift_reject", int'(bus._shiftReject), mon_e.rej);
            check("turn_state", int'(bus._turnState), mon_e.ts);
            check("left_lamp", int'(bus._leftLamp), mon_e.ll);
            check("right_lamp", int'(bus._rightLamp), mon_e.rl);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        _reset_n = 1'b0;
        lvl_sw = 1'b1; lvl_br = 1'b0; lvl_sz = 1'b1;
        bus._switch = 1'b1; bus._brake = 1'b0; bus._speedZero = 1'b1;
        bus._gearValid = 1'b0; bus._gearShift = G_PARK;
        bus._turnValid = 1'b0; bus._turnShift = T_NONE;
        model_reset();
        #12;
        check_zero_outputs("reset");

        // Power-up into PARK, then the interlocked PARK->FORWARD and gear saturation.
        release_reset();
        idle(2);
        cyc(1'b1, G_UP, 1'b0, T_NONE);
        idle(1);
        lvl_br = 1'b1;
        cyc(1'b1, G_UP, 1'b0, T_NONE);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, G_UP, 1'b0, T_NONE);
            idle(1);
        end
        cyc(1'b1, G_DOWN, 1'b0, T_NONE);
        cyc(1'b1, G_DOWN, 1'b0, T_NONE);
        lvl_sz = 1'b0;
        cyc(1'b1, G_PARK, 1'b0, T_NONE);
        for (int i = 0; i < 3; i++) cyc(1'b1, G_DOWN, 1'b0, T_NONE);
        idle(2);

        // Left blink through auto-cancel, then a manual cancel mid-blink.
        cyc(1'b0, G_PARK, 1'b1, T_UP);
        idle(60);
        cyc(1'b0, G_PARK, 1'b1, T_UP);
        idle(10);
        cyc(1'b0, G_PARK, 1'b1, T_DOWN);
        idle(3);

        // Hazard survives ignition off; second toggle clears it.
        cyc(1'b0, G_PARK, 1'b1, T_HAZ);
        idle(5);
        lvl_sw = 1'b0;
        idle(12);
        cyc(1'b0, G_PARK, 1'b1, T_HAZ);
        idle(3);

        // FORWARD 4 with RIGHT blinking, then asynchronous reset mid-cycle.
        lvl_sw = 1'b1; lvl_br = 1'b1; lvl_sz = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, G_UP, 1'b0, T_NONE);
            idle(1);
        end
        cyc(1'b0, G_PARK, 1'b1, T_DOWN);
        @(posedge clock);
        #3;
        _reset_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(posedge clock);
        release_reset();
        idle(2);

        run_random(1500, 1, 30, 1);
        run_random(1500, 4, 40, 3);
        run_random(1500, 15, 60, 2);

        @(posedge clock);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
